sort_loader: RTL

Operator-entry front end for the 8-lane 3-bit sorting network. It debounces the load push-button and captures one 3-bit switch value per press into eight slots. Once all eight slots are filled, it presents the packed 24-bit vector to the sorter's `nums` input and issues a one-cycle `start` pulse. The block replaces the fixed switch-to-vector mapping at the board top level, so all eight sorter inputs become user-settable.

---
 rtl/sort_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/sort_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the operator-entry loader, the sorter and the display
// stages: element width, lane count, element type and loader state encoding.
package sort_pkg;

  localparam int W = 3;
  localparam int N = 8;

  typedef logic [W-1:0] elem_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } load_state_t;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, level debouncer and a
// single-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  // A counter of this width reaches DEBOUNCE_CYCLES-1 exactly; minimum is 2.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta_q;
  logic             btn_s_q;
  logic             btn_stable_q;
  logic             btn_stable_prev_q;
  logic [CNT_W-1:0] db_cnt_q;

  // Bring the raw button into the clock domain through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn_in;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Accept a new level only after it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_stable_q <= 1'b0;
      db_cnt_q     <= '0;
    end else if (btn_s_q == btn_stable_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == CNT_LAST) begin
      btn_stable_q <= btn_s_q;
      db_cnt_q     <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  // Delayed copy of the stable level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_stable_prev_q <= 1'b0;
    end else begin
      btn_stable_prev_q <= btn_stable_q;
    end
  end

  // Only the press edge matters; releases are ignored.
  assign press = btn_stable_q & ~btn_stable_prev_q;

endmodule

// File: rtl/sort_loader.sv
// Operator-entry front end for the sorting network: one debounced button
// press captures the synchronized switch value into the next slot; once all
// slots are filled the packed vector is held valid and a start pulse issued.
module sort_loader #(
  parameter int W               = sort_pkg::W,
  parameter int N               = sort_pkg::N,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btnU,
  input  logic                 clr,
  input  logic [W-1:0]         sw,
  output logic [N*W-1:0]       nums,
  output logic                 nums_valid,
  output logic                 start,
  output logic [$clog2(N):0]   count
);

  import sort_pkg::*;

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

  load_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             start_q, start_d;
  logic [W-1:0]     sw_meta_q, sw_s_q;
  logic             press;

  // Slot-update controls decoded by the FSM.
  logic             load_en;    // write sw_s into the slot addressed by count
  logic             reload;     // restart from FULL: slot 0 <= sw_s, others 0
  logic             clear_all;  // wipe every slot

  logic [N-1:0][W-1:0] slots_w;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .btn_in(btnU),
    .press (press)
  );

  // Two-flop synchronizer for the element switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
    end
  end

  // FSM state, fill count and start pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      count_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      start_q <= start_d;
    end
  end

  // Next-state and slot controls; clr overrides any coincident press.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    start_d   = 1'b0;
    load_en   = 1'b0;
    reload    = 1'b0;
    clear_all = 1'b0;
    if (clr) begin
      clear_all = 1'b1;
      count_d   = '0;
      state_d   = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (press) begin
            load_en = 1'b1;
            count_d = count_q + CW'(1);
            if (count_q == COUNT_LAST) begin
              // Last slot written: the vector becomes valid next cycle.
              state_d = FULL;
              start_d = 1'b1;
            end
          end
        end
        FULL: begin
          if (press) begin
            reload  = 1'b1;
            count_d = CW'(1);
            state_d = FILL;
          end
        end
        default: begin
          state_d = FILL;
          count_d = '0;
        end
      endcase
    end
  end

  // One register per slot; each slot decodes its own write condition.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      localparam logic [CW-1:0] SLOT_IDX = CW'(gi);
      logic [W-1:0] slot_q, slot_d;

      // Select the next value for this slot from the FSM controls.
      always_comb begin
        slot_d = slot_q;
        if (clear_all) begin
          slot_d = '0;
        end else if (load_en && (count_q == SLOT_IDX)) begin
          slot_d = sw_s_q;
        end else if (reload) begin
          slot_d = (gi == 0) ? sw_s_q : '0;
        end
      end

      // Slot storage.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_q <= '0;
        end else begin
          slot_q <= slot_d;
        end
      end

      assign slots_w[gi] = slot_q;
    end
  endgenerate

  assign nums       = slots_w;
  assign nums_valid = (state_q == FULL);
  assign start      = start_q;
  assign count      = count_q;

endmodule
